int_ctrl: RTL and testbench

Programmable interrupt controller between the interrupt sources (TC1 IRQ, TC2 IRQ, external `interrupt`, spare lines) and the CPU's interrupt input. It latches each source as edge- or level-sensitive, applies a per-source enable mask, and resolves fixed priorities (index 0 highest). It tracks in-service state so only higher-priority sources can nest. Software accesses it as a Bridge-decoded peripheral through a claim / end-of-interrupt (EOI) register handshake.

---
 rtl/int_ctrl.sv | 131 +++++++++++++
 tb/tb_int_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: programmable interrupt controller.
// Latches edge/level sources, masks them, resolves fixed priority (index 0
// highest) under an in-service ceiling, and exposes a claim/EOI register
// handshake to software through the Bridge decode.
module int_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic [29:0]       Addr,
  input  logic              WE,
  input  logic              RE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic              IRQ,
  output logic [2:0]        IRQ_ID
);

  localparam logic [2:0] OFF_ENABLE    = 3'd0;
  localparam logic [2:0] OFF_MODE      = 3'd1;
  localparam logic [2:0] OFF_PENDING   = 3'd2;
  localparam logic [2:0] OFF_CLAIM     = 3'd3;
  localparam logic [2:0] OFF_EOI       = 3'd4;
  localparam logic [2:0] OFF_INSERVICE = 3'd5;
  localparam logic [3:0] NSRC4         = 4'(N_SRC);
  localparam int         PAD_W         = 32 - N_SRC;

  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] epend;
  logic [N_SRC-1:0] insvc;
  logic [N_SRC-1:0] prev;

  logic [2:0]       off;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] below_ceil;
  logic [N_SRC-1:0] elig;
  logic             valid;
  logic [2:0]       id;

  logic             claim;
  logic             eoi;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] claim_bit;
  logic [N_SRC-1:0] eoi_bit;
  logic [N_SRC-1:0] pclr;
  logic [N_SRC-1:0] epend_nxt;
  logic [N_SRC-1:0] insvc_nxt;

  // Address bits outside the decoded offset and data bits beyond the source
  // count carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{Addr[29:5], Addr[1:0], Din[31:N_SRC]};

  assign off  = Addr[4:2];
  // Level sources are seen live; edge sources only through their latch.
  assign pend = (mode & epend) | (~mode & irq_in);

  // Priority resolution: ceiling from in-service bits, then lowest eligible index.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    below_ceil = '0;
    for (int i = 0; i < N_SRC; i++) begin
      seen          = seen | insvc[i];
      below_ceil[i] = ~seen;
    end
    elig  = pend & enable & below_ceil;
    id    = 3'd7;
    valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        id    = 3'(i);
        valid = 1'b1;
      end
    end
  end

  assign IRQ    = valid;
  assign IRQ_ID = id;

  // Register read mux; CLAIM reads its id field (7) even with nothing eligible.
  always_comb begin
    Dout = '0;
    case (off)
      OFF_ENABLE:    Dout = {{PAD_W{1'b0}}, enable};
      OFF_MODE:      Dout = {{PAD_W{1'b0}}, mode};
      OFF_PENDING:   Dout = {{PAD_W{1'b0}}, pend};
      OFF_CLAIM:     Dout = {valid, 28'b0, id};
      OFF_INSERVICE: Dout = {{PAD_W{1'b0}}, insvc};
      default:       Dout = '0;
    endcase
  end

  // Next state of the edge latches and in-service bits with their precedences.
  always_comb begin
    claim     = RE && (off == OFF_CLAIM) && valid;
    eoi       = WE && (off == OFF_EOI) && ({1'b0, Din[2:0]} < NSRC4);
    rise      = irq_in & ~prev;
    claim_bit = claim ? (N_SRC'(1) << id) : '0;
    eoi_bit   = eoi ? (N_SRC'(1) << Din[2:0]) : '0;
    pclr      = (WE && (off == OFF_PENDING)) ? Din[N_SRC-1:0] : '0;
    // A new edge beats both the claim clear and the write-1-to-clear.
    epend_nxt = (epend & ~(pclr | (claim_bit & mode))) | (rise & mode);
    // Dropping a source to level mode discards its latched edge.
    if (WE && (off == OFF_MODE)) begin
      epend_nxt = epend_nxt & Din[N_SRC-1:0];
    end
    // Claim set wins over a same-cycle EOI on the same id.
    insvc_nxt = (insvc & ~eoi_bit) | claim_bit;
  end

  // State registers: configuration, edge detection, latches, in-service.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= '0;
      mode   <= '0;
      epend  <= '0;
      insvc  <= '0;
      prev   <= '0;
    end else begin
      if (WE && (off == OFF_ENABLE)) enable <= Din[N_SRC-1:0];
      if (WE && (off == OFF_MODE))   mode   <= Din[N_SRC-1:0];
      epend <= epend_nxt;
      insvc <= insvc_nxt;
      prev  <= irq_in;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed walk through the interrupt controller scenarios
// followed by randomized traffic, all checked against a per-source
// behavioural model of the register rules.
module tb_int_ctrl;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_in;
  logic [29:0] Addr;
  logic        WE;
  logic        RE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic [2:0]  IRQ_ID;

  int checks   = 0;
  int failures = 0;
  int stepno   = 0;

  // model state, one entry per source
  bit m_en    [N];
  bit m_mode  [N];
  bit m_epend [N];
  bit m_insvc [N];
  bit m_prev  [N];

  int_ctrl #(.N_SRC(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .Addr   (Addr),
    .WE     (WE),
    .RE     (RE),
    .Din    (Din),
    .Dout   (Dout),
    .IRQ    (IRQ),
    .IRQ_ID (IRQ_ID)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] A(input logic [2:0] o);
    return {25'd0, o, 2'd0};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_mode[i] = 0; m_epend[i] = 0; m_insvc[i] = 0; m_prev[i] = 0;
    end
  endfunction

  function automatic bit m_pend(input int i, input logic [5:0] irq);
    return m_mode[i] ? m_epend[i] : irq[i];
  endfunction

  // Expected winning id and read data for the current model state and inputs.
  function automatic void model_out(input logic [5:0] irq, input logic [2:0] off,
                                    output logic [2:0] eid, output logic [31:0] edout);
    int ceil_i;
    int win;
    int en_v, mode_v, pend_v, ins_v;
    ceil_i = N;
    for (int i = N - 1; i >= 0; i--) if (m_insvc[i]) ceil_i = i;
    win = 7;
    for (int i = ceil_i - 1; i >= 0; i--) if (m_pend(i, irq) && m_en[i]) win = i;
    en_v = 0; mode_v = 0; pend_v = 0; ins_v = 0;
    for (int i = 0; i < N; i++) begin
      en_v   += int'(m_en[i]) * (1 << i);
      mode_v += int'(m_mode[i]) * (1 << i);
      pend_v += int'(m_pend(i, irq)) * (1 << i);
      ins_v  += int'(m_insvc[i]) * (1 << i);
    end
    eid = 3'(win);
    case (off)
      3'd0: edout = 32'(en_v);
      3'd1: edout = 32'(mode_v);
      3'd2: edout = 32'(pend_v);
      3'd3: edout = (win != 7) ? (32'h8000_0000 + 32'(win)) : 32'h0000_0007;
      3'd5: edout = 32'(ins_v);
      default: edout = 32'h0;
    endcase
  endfunction

  // Advance the model across one clock edge.
  function automatic void model_edge(input logic rst, input logic [5:0] irq, input logic [2:0] off,
                                     input logic we, input logic re, input logic [31:0] din);
    logic [2:0]  eid;
    logic [31:0] ed;
    bit claim;
    bit ne, ni;
    if (rst) begin
      model_clear();
      return;
    end
    model_out(irq, off, eid, ed);
    claim = re && off == 3'd3 && eid != 3'd7;
    for (int i = 0; i < N; i++) begin
      ne = m_epend[i];
      if (we && off == 3'd2 && din[i]) ne = 0;
      if (claim && int'(eid) == i && m_mode[i]) ne = 0;
      if (m_mode[i] && irq[i] && !m_prev[i]) ne = 1;
      if (we && off == 3'd1 && !din[i]) ne = 0;
      ni = m_insvc[i];
      if (we && off == 3'd4 && int'(din[2:0]) == i) ni = 0;
      if (claim && int'(eid) == i) ni = 1;
      m_epend[i] = ne;
      m_insvc[i] = ni;
      m_prev[i]  = irq[i];
      if (we && off == 3'd0) m_en[i] = din[i];
      if (we && off == 3'd1) m_mode[i] = din[i];
    end
  endfunction

  // One cycle: drive, check combinational outputs mid-cycle, advance model.
  task automatic step(input logic rst, input logic [5:0] irq, input logic [29:0] addr,
                      input logic we, input logic re, input logic [31:0] din,
                      input int lit_id, input longint lit_dout);
    logic [2:0]  eid;
    logic [31:0] edout;
    stepno++;
    reset = rst; irq_in = irq; Addr = addr; WE = we; RE = re; Din = din;
    #1;
    model_out(irq, addr[4:2], eid, edout);
    checks++;
    assert (IRQ === (eid != 3'd7)) else begin
      failures++;
      $error("FAIL irq step=%0d observed=%b expected=%b", stepno, IRQ, (eid != 3'd7));
    end
    checks++;
    assert (IRQ_ID === eid) else begin
      failures++;
      $error("FAIL irq_id step=%0d observed=%0d expected=%0d", stepno, IRQ_ID, eid);
    end
    checks++;
    assert (Dout === edout) else begin
      failures++;
      $error("FAIL dout step=%0d off=%0d observed=%h expected=%h", stepno, addr[4:2], Dout, edout);
    end
    if (lit_id >= 0) begin
      checks++;
      assert (IRQ_ID === 3'(lit_id)) else begin
        failures++;
        $error("FAIL plan_id step=%0d observed=%0d expected=%0d", stepno, IRQ_ID, lit_id);
      end
    end
    if (lit_dout >= 0) begin
      checks++;
      assert (Dout === 32'(lit_dout)) else begin
        failures++;
        $error("FAIL plan_dout step=%0d observed=%h expected=%h", stepno, Dout, 32'(lit_dout));
      end
    end
    model_edge(rst, irq, addr[4:2], we, re, din);
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] o, input logic [5:0] irq, input int lid, input longint ld);
    step(1'b0, irq, A(o), 1'b0, 1'b0, 32'h0, lid, ld);
  endtask

  task automatic clm(input logic [5:0] irq, input int lid, input longint ld);
    step(1'b0, irq, A(3'd3), 1'b0, 1'b1, 32'h0, lid, ld);
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] d, input logic [5:0] irq, input int lid);
    step(1'b0, irq, A(o), 1'b1, 1'b0, d, lid, -1);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rdin;
    reset = 1'b1; irq_in = '0; Addr = '0; WE = 1'b0; RE = 1'b0; Din = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    step(1'b1, 6'h00, A(3'd3), 1'b0, 1'b0, 32'h0, 7, 32'h7);
    rd(3'd0, 6'h00, 7, 32'h0);
    // basic edge claim
    wr(3'd0, 32'h3F, 6'h00, 7);
    wr(3'd1, 32'h3F, 6'h00, 7);
    rd(3'd0, 6'h04, 7, 32'h3F);
    clm(6'h00, 2, 32'h8000_0002);
    rd(3'd5, 6'h00, 7, 32'h04);
    rd(3'd2, 6'h00, 7, 32'h00);
    // nesting
    rd(3'd2, 6'h10, 7, -1);
    rd(3'd2, 6'h00, 7, 32'h10);
    rd(3'd2, 6'h02, 7, -1);
    clm(6'h00, 1, 32'h8000_0001);
    wr(3'd4, 32'd1, 6'h00, 7);
    wr(3'd4, 32'd2, 6'h00, 7);
    rd(3'd0, 6'h00, 4, 32'h3F);
    clm(6'h00, 4, 32'h8000_0004);
    wr(3'd4, 32'd4, 6'h00, 7);
    // level mode
    wr(3'd1, 32'h00, 6'h00, 7);
    wr(3'd0, 32'h01, 6'h00, 7);
    rd(3'd3, 6'h01, 0, 32'h8000_0000);
    clm(6'h01, 0, -1);
    rd(3'd5, 6'h01, 7, 32'h01);
    wr(3'd4, 32'd0, 6'h01, 7);
    rd(3'd2, 6'h01, 0, 32'h01);
    rd(3'd2, 6'h00, 7, 32'h00);
    // masking
    wr(3'd0, 32'h00, 6'h00, 7);
    wr(3'd1, 32'h3F, 6'h00, 7);
    rd(3'd2, 6'h08, 7, -1);
    rd(3'd2, 6'h00, 7, 32'h08);
    wr(3'd0, 32'h08, 6'h00, 7);
    rd(3'd0, 6'h00, 3, 32'h08);
    wr(3'd2, 32'h08, 6'h00, 3);
    rd(3'd2, 6'h00, 7, 32'h00);
    // simultaneous sources, claim against a fresh edge, out-of-range EOI
    wr(3'd0, 32'h3F, 6'h00, 7);
    rd(3'd2, 6'h21, 7, -1);
    clm(6'h00, 0, 32'h8000_0000);
    wr(3'd4, 32'd0, 6'h00, 7);
    rd(3'd2, 6'h00, 5, 32'h20);
    clm(6'h20, 5, 32'h8000_0005);
    rd(3'd2, 6'h00, 7, 32'h20);
    wr(3'd4, 32'd6, 6'h00, 7);
    rd(3'd5, 6'h00, 7, 32'h20);
    // reset mid-service
    wr(3'd4, 32'd5, 6'h00, 7);
    wr(3'd2, 32'h20, 6'h00, 5);
    rd(3'd2, 6'h04, 7, 32'h00);
    clm(6'h00, 2, 32'h8000_0002);
    rd(3'd2, 6'h10, 7, -1);
    rd(3'd2, 6'h00, 7, 32'h10);
    rd(3'd5, 6'h00, 7, 32'h04);
    step(1'b1, 6'h00, A(3'd3), 1'b0, 1'b0, 32'h0, 7, 32'h7);
    rd(3'd3, 6'h00, 7, 32'h0000_0007);
    rd(3'd5, 6'h00, 7, 32'h00);
    rd(3'd0, 6'h00, 7, 32'h00);

    // randomized traffic
    wr(3'd0, 32'h3F, 6'h00, -1);
    for (int k = 0; k < 600; k++) begin
      ro   = 3'($urandom_range(0, 7));
      rdin = $urandom;
      if (ro == 3'd4) rdin[2:0] = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 99) == 0), 6'($urandom & $urandom),
           {25'($urandom), ro, 2'($urandom)},
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), rdin, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
